// File: rtl/avmm_rom_responder.sv
`default_nettype none
// ============================================================================
// Module : avmm_rom_responder
// Brief  : Avalon-MM read-only ROM slave with fixed read latency, a cap on
//          pending reads and programmable stall injection.
// Rev    : 1.0  initial release
// ============================================================================
module avmm_rom_responder #(
  parameter int    DATA_WIDTH  = 64,
  parameter int    DEPTH       = 16,
  parameter int    LATENCY     = 2,
  parameter int    MAX_PENDING = 4,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic [15:0]           rd_count,
  output logic                  addr_err
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] MAX_P      = 4'(MAX_PENDING);
  localparam logic [3:0] STALL_LOAD = 4'(WAIT_CYCLES);

  logic                  init_cycle;
  logic [3:0]            stall_cnt;
  logic [3:0]            outstanding;
  logic                  accept;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rom_word;
  logic [DATA_WIDTH-1:0] lookup;
  logic [LATENCY-1:0]    vld;
  logic [DATA_WIDTH-1:0] dat [LATENCY];

  // Only registered state (plus reset) feeds waitrequest; read/address never do.
  assign waitrequest = rst | init_cycle | (stall_cnt != 4'd0) | (outstanding == MAX_P);
  assign accept      = read & ~waitrequest;
  assign in_range    = (address[31:AW] == '0);
  assign lookup      = in_range ? rom_word : '0;

  generate
    if (1) begin : g_pattern_rom
      logic [7:0] base;
      assign base = 8'({address[AW-1:0], 3'b000});
      always_comb begin
        rom_word = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          rom_word[8*b +: 8] = base + 8'(b);
        end
      end
    end
  endgenerate

  // Each stage keeps its data until a new valid word enters, so readdata holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= accept;
      if (accept) begin
        dat[0] <= lookup;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign readdatavalid = vld[LATENCY-1];
  assign readdata      = dat[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cycle  <= 1'b1;
      stall_cnt   <= 4'd0;
      outstanding <= 4'd0;
      rd_count    <= 16'd0;
      addr_err    <= 1'b0;
    end else begin
      init_cycle <= 1'b0;
      if (accept) begin
        stall_cnt <= STALL_LOAD;
      end else if (stall_cnt != 4'd0) begin
        stall_cnt <= stall_cnt - 4'd1;
      end
      case ({accept, readdatavalid})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (accept) begin
        rd_count <= rd_count + 16'd1;
      end
      if (accept && !in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avmm_rom_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_avmm_rom_responder
// Brief  : Self-checking bench: timestamped response-queue model plus
//          directed stall and pending-cap scenarios.
// Rev    : 1.0  initial release
// ============================================================================
module tb_avmm_rom_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [31:0] address = '0;
  logic        read    = 1'b0;
  logic [63:0] readdata;
  logic        readdatavalid, waitrequest, addr_err;
  logic [15:0] rd_count;

  avmm_rom_responder #(.DATA_WIDTH(64), .DEPTH(16), .LATENCY(2), .MAX_PENDING(4),
                       .WAIT_CYCLES(0), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .rd_count(rd_count), .addr_err(addr_err));

  // Stall-injection instance
  logic [31:0] s_address = '0;
  logic        s_read    = 1'b0;
  logic [63:0] s_readdata;
  logic        s_readdatavalid, s_waitrequest, s_addr_err;
  logic [15:0] s_rd_count;

  avmm_rom_responder #(.DATA_WIDTH(64), .DEPTH(16), .LATENCY(2), .MAX_PENDING(4),
                       .WAIT_CYCLES(2), .INIT_FILE("")) dut_stall (
    .clk(clk), .rst(rst), .address(s_address), .read(s_read), .readdata(s_readdata),
    .readdatavalid(s_readdatavalid), .waitrequest(s_waitrequest),
    .rd_count(s_rd_count), .addr_err(s_addr_err));

  // Single-pending, latency-3 instance
  logic [31:0] p_address = '0;
  logic        p_read    = 1'b0;
  logic [63:0] p_readdata;
  logic        p_readdatavalid, p_waitrequest, p_addr_err;
  logic [15:0] p_rd_count;

  avmm_rom_responder #(.DATA_WIDTH(64), .DEPTH(16), .LATENCY(3), .MAX_PENDING(1),
                       .WAIT_CYCLES(0), .INIT_FILE("")) dut_pend (
    .clk(clk), .rst(rst), .address(p_address), .read(p_read), .readdata(p_readdata),
    .readdatavalid(p_readdatavalid), .waitrequest(p_waitrequest),
    .rd_count(p_rd_count), .addr_err(p_addr_err));

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] pat(input int i);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'((8 * i + b) % 256);
    return w;
  endfunction

  function automatic logic [63:0] rom_val(input logic [31:0] a);
    return (a < 32'd16) ? pat(int'(a)) : 64'd0;
  endfunction

  // Reference model for the default instance: responses carry their due cycle.
  typedef struct {
    int          due;
    logic [63:0] d;
  } resp_t;

  resp_t       q[$];
  int          cyc;
  bit          m_init;
  int          m_stall;
  int          m_out;
  int          m_cnt;
  bit          m_err;
  logic [63:0] m_data;
  int          vcount;
  logic [63:0] last_rd;

  task automatic model_reset();
    q.delete();
    m_init  = 1'b1;
    m_stall = 0;
    m_out   = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_data  = '0;
  endtask

  task automatic tick(input bit r, input bit rd, input logic [31:0] a, output bit acc);
    bit    exp_v, exp_w;
    resp_t e;
    @(posedge clk); #1;
    cyc++;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    if (exp_v) m_data = q[0].d;
    if (readdatavalid === 1'b1) begin vcount++; last_rd = readdata; end
    total++;
    if (readdatavalid !== exp_v) begin
      bad++; $display("FAIL readdatavalid cyc=%0d got=%b exp=%b", cyc, readdatavalid, exp_v);
    end
    total++;
    if (readdata !== m_data) begin
      bad++; $display("FAIL readdata cyc=%0d got=%h exp=%h", cyc, readdata, m_data);
    end
    total++;
    if (rd_count !== 16'(m_cnt)) begin
      bad++; $display("FAIL rd_count cyc=%0d got=%0d exp=%0d", cyc, rd_count, m_cnt);
    end
    total++;
    if (addr_err !== m_err) begin
      bad++; $display("FAIL addr_err cyc=%0d got=%b exp=%b", cyc, addr_err, m_err);
    end
    rst = r; read = rd; address = a;
    #1;
    exp_w = r || m_init || (m_stall != 0) || (m_out == 4);
    total++;
    if (waitrequest !== exp_w) begin
      bad++; $display("FAIL waitrequest cyc=%0d got=%b exp=%b", cyc, waitrequest, exp_w);
    end
    acc = !r && rd && !exp_w;
    if (r) begin
      model_reset();
    end else begin
      if (exp_v) begin void'(q.pop_front()); m_out--; end
      if (acc) begin
        e.due = cyc + 2;
        e.d   = rom_val(a);
        q.push_back(e);
        m_out++;
        m_cnt = (m_cnt + 1) % 65536;
        if (a >= 32'd16) m_err = 1'b1;
      end
      m_stall = (m_stall > 0) ? m_stall - 1 : 0;
      m_init  = 1'b0;
    end
  endtask

  task automatic read_until_accept(input logic [31:0] a);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 10) begin tick(1'b0, 1'b1, a, acc); n++; end
    total++;
    if (!acc) begin bad++; $display("FAIL accept_timeout addr=%0d got=0 exp=1", a); end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'd0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    tick(1'b1, 1'b0, 32'd0, acc);
    tick(1'b1, 1'b0, 32'd0, acc);
  endtask

  task automatic test_stall();
    int          acc_cyc[$];
    logic [63:0] got[$];
    int          a = 1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (s_readdatavalid === 1'b1) got.push_back(s_readdata);
      s_read = (a <= 3); s_address = a;
      #1;
      if (s_read && s_waitrequest === 1'b0) begin acc_cyc.push_back(c); a++; end
    end
    s_read = 1'b0;
    total++;
    if (acc_cyc.size() != 3) begin
      bad++; $display("FAIL stall_accepts got=%0d exp=3", acc_cyc.size());
    end else begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 3) begin
        bad++; $display("FAIL stall_gap1 got=%0d exp=3", acc_cyc[1] - acc_cyc[0]);
      end
      total++;
      if (acc_cyc[2] - acc_cyc[1] != 3) begin
        bad++; $display("FAIL stall_gap2 got=%0d exp=3", acc_cyc[2] - acc_cyc[1]);
      end
    end
    total++;
    if (got.size() != 3) begin
      bad++; $display("FAIL stall_responses got=%0d exp=3", got.size());
    end else begin
      total++;
      if (got[0] !== 64'h0F0E0D0C0B0A0908 || got[1] !== 64'h1716151413121110 ||
          got[2] !== 64'h1F1E1D1C1B1A1918) begin
        bad++; $display("FAIL stall_data got=%h %h %h exp=0f0e..08 1716..10 1f1e..18",
                        got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_pending();
    bit          w[20];
    bit          v[20];
    logic [63:0] d[20];
    int          t = -1;
    p_read = 1'b1; p_address = 32'd5;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      v[c] = (p_readdatavalid === 1'b1);
      d[c] = p_readdata;
      #1;
      w[c] = (p_waitrequest !== 1'b0);
      if (t < 0 && !w[c]) t = c;
    end
    p_read = 1'b0;
    total++;
    if (t < 0 || t > 14) begin
      bad++; $display("FAIL pend_first_accept got=%0d exp=0..14", t);
    end else begin
      total++;
      if (!(w[t+1] && w[t+2] && w[t+3])) begin
        bad++; $display("FAIL pend_wait got=%b%b%b exp=111", w[t+1], w[t+2], w[t+3]);
      end
      total++;
      if (v[t+1] || v[t+2] || !v[t+3]) begin
        bad++; $display("FAIL pend_valid got=%b%b%b exp=001", v[t+1], v[t+2], v[t+3]);
      end
      total++;
      if (d[t+3] !== pat(5)) begin
        bad++; $display("FAIL pend_data got=%h exp=%h", d[t+3], pat(5));
      end
      total++;
      if (w[t+4]) begin
        bad++; $display("FAIL pend_next_accept got=wait exp=accept at t+4");
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    do_reset();
    total++;
    if (waitrequest !== 1'b1 || readdatavalid !== 1'b0 || rd_count !== 16'd0) begin
      bad++; $display("FAIL reset_state got=w%b v%b c%0d exp=w1 v0 c0",
                      waitrequest, readdatavalid, rd_count);
    end
  endtask

  task automatic test_first_read();
    vcount = 0;
    read_until_accept(32'd0);
    idle(3);
    total++;
    if (vcount != 1 || last_rd !== 64'h0706050403020100) begin
      bad++; $display("FAIL first_read got=%0d/%h exp=1/0706050403020100", vcount, last_rd);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_reset();
    idle(1);
    vcount = 0;
    for (int i = 0; i <= 8; i++) begin
      tick(1'b0, 1'b1, 32'(i), acc);
      total++;
      if (!acc) begin bad++; $display("FAIL b2b_accept addr=%0d got=0 exp=1", i); end
    end
    idle(4);
    total++;
    if (vcount != 9 || last_rd !== 64'h4746454443424140 || rd_count !== 16'd9 || addr_err !== 1'b0) begin
      bad++; $display("FAIL b2b_summary got=%0d/%h/%0d/%b exp=9/4746454443424140/9/0",
                      vcount, last_rd, rd_count, addr_err);
    end
  endtask

  task automatic test_addr_err();
    do_reset();
    vcount = 0;
    read_until_accept(32'd16);
    read_until_accept(32'd1);
    idle(4);
    total++;
    if (vcount != 2 || last_rd !== 64'h0F0E0D0C0B0A0908 || addr_err !== 1'b1) begin
      bad++; $display("FAIL addr_err_seq got=%0d/%h/%b exp=2/0f0e0d0c0b0a0908/1",
                      vcount, last_rd, addr_err);
    end
  endtask

  task automatic test_reset_flush();
    bit acc;
    do_reset();
    read_until_accept(32'd2);
    vcount = 0;
    tick(1'b1, 1'b0, 32'd0, acc);
    idle(5);
    total++;
    if (vcount != 0 || rd_count !== 16'd0) begin
      bad++; $display("FAIL flush got=%0d/%0d exp=0/0", vcount, rd_count);
    end
    read_until_accept(32'd3);
    idle(3);
    total++;
    if (vcount != 1 || last_rd !== pat(3)) begin
      bad++; $display("FAIL recover got=%0d/%h exp=1/%h", vcount, last_rd, pat(3));
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 19)), acc);
    end
    idle(4);
  endtask

  initial begin
    cyc = 0; vcount = 0; last_rd = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_stall();
    test_pending();
    test_reset();
    test_first_read();
    test_back_to_back();
    test_addr_err();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
